// File: rtl/gamma_lut_loader.sv
// Frames a raw byte stream (HDR0 HDR1 payload checksum) into a gamma LUT packet.
// The payload is buffered and replayed only after its checksum verifies.
module gamma_lut_loader #(
    parameter logic [7:0] HDR0    = 8'hA5,
    parameter logic [7:0] HDR1    = 8'h5A,
    parameter int         NBYTES  = 256,
    parameter int         TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       SOP,
    output logic       EOP,
    output logic       VLD,
    output logic [7:0] packet_data,
    output logic       load_done,
    output logic       chk_err,
    output logic       tmo_err,
    output logic       busy
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [GAP_W-1:0] TMO_LAST = GAP_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SYNC     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD  = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_PREFETCH = 3'd4;
    localparam logic [2:0] ST_REPLAY   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             vld_q, vld_d;
    logic [7:0]       packet_data_q, packet_data_d;
    logic             load_done_q, load_done_d;
    logic             chk_err_q, chk_err_d;
    logic             tmo_err_q, tmo_err_d;

    logic [7:0]       sum_next;
    logic             mem_we;
    logic             in_frame;
    logic [7:0]       mem [NBYTES];

    // idx_q addresses the single RAM port for both payload writes and replay reads
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= rx_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        gap_d         = gap_q;
        sop_d         = 1'b0;
        eop_d         = 1'b0;
        vld_d         = 1'b0;
        packet_data_d = packet_data_q;
        load_done_d   = 1'b0;
        chk_err_d     = 1'b0;
        tmo_err_d     = 1'b0;
        mem_we        = 1'b0;
        sum_next      = sum_q + rx_data;
        in_frame      = (state_q == ST_SYNC) || (state_q == ST_PAYLOAD) ||
                        (state_q == ST_CHECK);

        // Inter-byte watchdog; a byte in the same cycle always wins over expiry
        if (in_frame) begin
            if (rx_valid) begin
                gap_d = '0;
            end else if (gap_q == TMO_LAST) begin
                tmo_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == HDR0)) begin
                    state_d = ST_SYNC;
                    gap_d   = '0;
                end
            end
            ST_SYNC: begin
                if (rx_valid) begin
                    if (rx_data == HDR1) begin
                        state_d = ST_PAYLOAD;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else if (rx_data != HDR0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    mem_we = 1'b1;
                    sum_d  = sum_next;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (sum_next == 8'h00) begin
                        state_d = ST_PREFETCH;
                        idx_d   = '0;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_PREFETCH: begin
                packet_data_d = mem[idx_q];
                vld_d         = 1'b1;
                sop_d         = 1'b1;
                eop_d         = (idx_q == LAST_IDX);
                idx_d         = idx_q + IDX_W'(1);
                state_d       = ST_REPLAY;
            end
            ST_REPLAY: begin
                // The cycle showing EOP is the last replay cycle
                if (eop_q) begin
                    load_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    packet_data_d = mem[idx_q];
                    vld_d         = 1'b1;
                    eop_d         = (idx_q == LAST_IDX);
                    idx_d         = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            gap_q         <= '0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            vld_q         <= 1'b0;
            packet_data_q <= '0;
            load_done_q   <= 1'b0;
            chk_err_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            gap_q         <= gap_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
            vld_q         <= vld_d;
            packet_data_q <= packet_data_d;
            load_done_q   <= load_done_d;
            chk_err_q     <= chk_err_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign SOP         = sop_q;
    assign EOP         = eop_q;
    assign VLD         = vld_q;
    assign packet_data = packet_data_q;
    assign load_done   = load_done_q;
    assign chk_err     = chk_err_q;
    assign tmo_err     = tmo_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Bench for gamma_lut_loader: frame table plus timeout, replay-interference and reset sequences.
module tb_gamma_lut_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       SOP, EOP, VLD;
    logic [7:0] packet_data;
    logic       load_done, chk_err, tmo_err, busy;

    gamma_lut_loader dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .SOP(SOP), .EOP(EOP), .VLD(VLD), .packet_data(packet_data),
        .load_done(load_done), .chk_err(chk_err), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int prot_err = 0;
    int ld_cnt = 0, chk_cnt = 0, tmo_cnt = 0, eop_cnt = 0;
    int ld_cyc = -1, chk_cyc = -1, tmo_cyc = -1, sop_cyc = -1, eop_cyc = -1;
    int pkt_bytes = 0;
    bit in_pkt = 1'b0;
    bit have_prev = 1'b0;
    logic [7:0] prev_pd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (rst) begin
            in_pkt    = 1'b0;
            pkt_bytes = 0;
            have_prev = 1'b0;
            sb.delete();
        end else begin
            if (load_done) begin ld_cnt++; ld_cyc = cyc; end
            if (chk_err)   begin chk_cnt++; chk_cyc = cyc; end
            if (tmo_err)   begin tmo_cnt++; tmo_cyc = cyc; end
            if (VLD) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL replay_unexpected: got VLD with data=%h, expected no VLD", packet_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (packet_data !== e.data || SOP !== e.sop || EOP !== e.eop) begin
                        fails++;
                        $display("FAIL replay_byte[%0d]: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b",
                                 pkt_bytes, packet_data, SOP, EOP, e.data, e.sop, e.eop);
                    end
                end
                if (SOP) begin
                    sop_cyc   = cyc;
                    in_pkt    = 1'b1;
                    pkt_bytes = 0;
                end else if (!in_pkt) begin
                    prot_err++;
                end
                pkt_bytes++;
                if (EOP) begin
                    eop_cyc = cyc;
                    eop_cnt++;
                    in_pkt  = 1'b0;
                end
            end else begin
                if (SOP || EOP) prot_err++;
                if (in_pkt) prot_err++;
                if (have_prev && packet_data !== prev_pd) prot_err++;
            end
            prev_pd   = packet_data;
            have_prev = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // pat: 0 ramp, 1 random, 2 all FF, 3 all 00, 4 alternating 55/AA
    task automatic send_frame(input int pat, input logic [7:0] delta, input int gap,
                              input int hdr_gap, output int chk_c);
        logic [7:0] pl [256];
        logic [7:0] s;
        logic [7:0] ck;
        exp_t e;
        s = 8'h00;
        for (int k = 0; k < 256; k++) begin
            case (pat)
                0:       pl[k] = 8'(k);
                1:       pl[k] = 8'($urandom_range(0, 255));
                2:       pl[k] = 8'hFF;
                3:       pl[k] = 8'h00;
                default: pl[k] = (k % 2 == 0) ? 8'h55 : 8'hAA;
            endcase
            s = s + pl[k];
        end
        ck = 8'h00 - s + delta;
        if (delta == 8'h00) begin
            for (int k = 0; k < 256; k++) begin
                e.data = pl[k];
                e.sop  = (k == 0);
                e.eop  = (k == 255);
                sb.push_back(e);
            end
        end
        drive(8'hA5);
        idle(hdr_gap);
        drive(8'h5A);
        idle(gap);
        for (int k = 0; k < 256; k++) begin
            drive(pl[k]);
            idle(gap);
        end
        chk_c = cyc;
        drive(ck);
    endtask

    typedef struct {
        int         pat;
        logic [7:0] delta;
        int         gap;
        int         prefix;
        int         exp_load;
        int         exp_chk;
    } vec_t;

    vec_t vt [8];

    initial begin
        int c, last, ld0, ck0, tm0, eo0;
        bit found;

        vt[0] = '{0, 8'h00, 0, 0, 1, 0};
        vt[1] = '{0, 8'h01, 0, 0, 0, 1};
        vt[2] = '{1, 8'h00, 2, 0, 1, 0};
        vt[3] = '{2, 8'h00, 1, 0, 1, 0};
        vt[4] = '{1, 8'h00, 0, 1, 1, 0};
        vt[5] = '{1, 8'h40, 1, 0, 0, 1};
        vt[6] = '{3, 8'h00, 0, 0, 1, 0};
        vt[7] = '{4, 8'h00, 0, 2, 1, 0};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {25'd0, SOP, EOP, VLD, load_done, chk_err, tmo_err, busy}, 32'd0);
        check("reset_packet_data", packet_data, 8'h00);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            ld0 = ld_cnt;
            ck0 = chk_cnt;
            if (vt[i].prefix == 1) begin
                drive(8'h00);
                drive(8'hA5);
            end else if (vt[i].prefix == 2) begin
                drive(8'hA5);
                drive(8'h33);
            end
            send_frame(vt[i].pat, vt[i].delta, vt[i].gap, 0, c);
            idle(270);
            check($sformatf("v%0d_load_count", i), ld_cnt - ld0, vt[i].exp_load);
            check($sformatf("v%0d_chk_err_count", i), chk_cnt - ck0, vt[i].exp_chk);
            if (vt[i].exp_load != 0) begin
                check($sformatf("v%0d_sop_cycle", i), sop_cyc, c + 2);
                check($sformatf("v%0d_eop_cycle", i), eop_cyc, c + 257);
                check($sformatf("v%0d_load_done_cycle", i), ld_cyc, c + 258);
            end
            if (vt[i].exp_chk != 0) begin
                check($sformatf("v%0d_chk_err_cycle", i), chk_cyc, c + 1);
            end
            check($sformatf("v%0d_busy_after", i), busy, 1'b0);
            check($sformatf("v%0d_scoreboard_empty", i), sb.size(), 0);
        end

        // Timeout after a partial payload
        tm0 = tmo_cnt;
        ld0 = ld_cnt;
        drive(8'hA5);
        drive(8'h5A);
        last = 0;
        for (int k = 0; k < 10; k++) begin
            last = cyc;
            drive(8'(k + 3));
        end
        idle(1100);
        check("tmo_count", tmo_cnt - tm0, 1);
        check("tmo_cycle", tmo_cyc, last + 1001);
        check("tmo_busy_after", busy, 1'b0);
        check("tmo_no_load", ld_cnt - ld0, 0);
        send_frame(1, 8'h00, 1, 0, c);
        idle(270);
        check("post_tmo_load", ld_cnt - ld0, 1);
        check("post_tmo_load_cycle", ld_cyc, c + 258);

        // A 999-cycle gap inside a frame must not time out
        tm0 = tmo_cnt;
        ld0 = ld_cnt;
        send_frame(0, 8'h00, 0, 999, c);
        idle(270);
        check("gap999_no_tmo", tmo_cnt - tm0, 0);
        check("gap999_load", ld_cnt - ld0, 1);

        // Traffic during replay is ignored
        ld0 = ld_cnt;
        eo0 = eop_cnt;
        send_frame(1, 8'h00, 0, 0, c);
        idle(5);
        drive(8'hA5);
        drive(8'h5A);
        for (int k = 0; k < 20; k++) drive(8'($urandom_range(0, 255)));
        idle(300);
        check("rx_in_replay_load", ld_cnt - ld0, 1);
        check("rx_in_replay_eop", eop_cnt - eo0, 1);
        check("rx_in_replay_busy", busy, 1'b0);
        check("rx_in_replay_sb", sb.size(), 0);

        // Reset in the middle of replay
        ld0 = ld_cnt;
        eo0 = eop_cnt;
        send_frame(4, 8'h00, 0, 0, c);
        found = 1'b0;
        for (int w = 0; w < 400 && !found; w++) begin
            idle(1);
            if (in_pkt && pkt_bytes == 100) found = 1'b1;
        end
        check("rst_wait_byte100", found, 1'b1);
        rst = 1'b1;
        idle(1);
        check("rst_mid_flags", {25'd0, SOP, EOP, VLD, load_done, chk_err, tmo_err, busy}, 32'd0);
        check("rst_mid_packet_data", packet_data, 8'h00);
        rst = 1'b0;
        idle(300);
        check("rst_mid_no_load", ld_cnt - ld0, 0);
        check("rst_mid_no_eop", eop_cnt - eo0, 0);
        send_frame(0, 8'h00, 0, 0, c);
        idle(270);
        check("post_rst_load", ld_cnt - ld0, 1);
        check("post_rst_eop_cycle", eop_cyc, c + 257);

        check("protocol_errors", prot_err, 0);
        check("final_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
